// File: rtl/ring3_sink.sv
// Clocked sink for a 3-rail NCL ring: synchronizes and filters the 1-of-3 code,
// closes the ring with TCOMP, and streams decoded tokens on a valid/ready port.
module ring3_sink #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 2,
    parameter int CNT_W         = 16,
    parameter int SEQ_STEP      = 1
) (
    input  logic             clk,
    input  logic             init,
    input  logic [2:0]       C,
    output logic             TCOMP,
    output logic [1:0]       dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             code_err,
    output logic             seq_err,
    output logic [CNT_W-1:0] tok_count
);
    localparam int RW = $clog2(STABLE_CYCLES + 1);
    localparam logic [RW-1:0] STABLE_V = RW'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        S_NULL = 2'd0,
        S_HOLD = 2'd1,
        S_DATA = 2'd2
    } state_t;

    function automatic logic is_data(input logic [2:0] c);
        return $onehot(c);
    endfunction

    function automatic logic is_illegal(input logic [2:0] c);
        return (c[0] & c[1]) | (c[0] & c[2]) | (c[1] & c[2]);
    endfunction

    function automatic logic [1:0] rail_index(input logic [2:0] c);
        case (c)
            3'b010:  return 2'd1;
            3'b100:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] next_ref(input logic [1:0] r);
        return 2'((int'(r) + SEQ_STEP) % 3);
    endfunction

    logic [2:0]    sync_r [SYNC_STAGES];
    logic [2:0]    sync_out_s;
    logic [2:0]    prev_r;
    logic [RW-1:0] run_r;
    logic [RW-1:0] run_now_s;
    logic [2:0]    qual_r;
    logic [2:0]    qual_s;
    logic [2:0]    held_r;
    state_t        state_r;
    logic          space_s;
    logic          load_s;
    logic [1:0]    load_idx_s;
    logic [1:0]    seq_ref_r;
    logic          seq_valid_r;

    assign sync_out_s = sync_r[SYNC_STAGES-1];

    // Run-length filter: the qualified code only moves after enough identical samples.
    always_comb begin
        run_now_s = RW'(1);
        if (sync_out_s == prev_r) begin
            if (run_r == STABLE_V) begin
                run_now_s = run_r;
            end else begin
                run_now_s = run_r + RW'(1);
            end
        end else begin
            run_now_s = RW'(1);
        end
        if (run_now_s >= STABLE_V) begin
            qual_s = sync_out_s;
        end else begin
            qual_s = qual_r;
        end
    end

    // Load decision: a token is taken when DATA is pending and the output has room.
    always_comb begin
        space_s    = !dout_valid || dout_ready;
        load_idx_s = rail_index(qual_s);
        if (state_r == S_NULL) begin
            load_s = space_s && is_data(qual_s);
        end else if (state_r == S_HOLD) begin
            load_s = space_s && (qual_s == held_r);
        end else begin
            load_s = 1'b0;
        end
    end

    // Synchronizer chain on each rail.
    always_ff @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= 3'b000;
        end else begin
            sync_r[0] <= C;
            for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
        end
    end

    // Handshake FSM with filter state, output register, counters and sticky flags.
    always_ff @(posedge clk) begin
        if (init) begin
            prev_r      <= 3'b000;
            run_r       <= '0;
            qual_r      <= 3'b000;
            held_r      <= 3'b000;
            state_r     <= S_NULL;
            TCOMP       <= 1'b0;
            dout        <= 2'd0;
            dout_valid  <= 1'b0;
            code_err    <= 1'b0;
            seq_err     <= 1'b0;
            tok_count   <= '0;
            seq_ref_r   <= 2'd0;
            seq_valid_r <= 1'b0;
        end else begin
            prev_r <= sync_out_s;
            run_r  <= run_now_s;
            qual_r <= qual_s;

            if (load_s) begin
                dout        <= load_idx_s;
                dout_valid  <= 1'b1;
                TCOMP       <= 1'b1;
                tok_count   <= tok_count + CNT_W'(1);
                held_r      <= qual_s;
                seq_ref_r   <= load_idx_s;
                seq_valid_r <= 1'b1;
                if (seq_valid_r && (load_idx_s != next_ref(seq_ref_r))) seq_err <= 1'b1;
                state_r     <= S_DATA;
            end else begin
                if (dout_valid && dout_ready) dout_valid <= 1'b0;
                case (state_r)
                    S_NULL: begin
                        if (is_data(qual_s)) begin
                            held_r  <= qual_s;
                            state_r <= S_HOLD;
                        end else if (is_illegal(qual_s)) begin
                            code_err <= 1'b1;
                        end
                    end
                    S_HOLD: begin
                        // Anything other than the pending DATA abandons the hold.
                        if (qual_s != held_r) begin
                            if (qual_s != 3'b000) code_err <= 1'b1;
                            state_r <= S_NULL;
                        end
                    end
                    S_DATA: begin
                        if (qual_s == 3'b000) begin
                            TCOMP   <= 1'b0;
                            state_r <= S_NULL;
                        end else if (qual_s != held_r) begin
                            code_err <= 1'b1;
                        end
                    end
                    default: begin
                        TCOMP   <= 1'b0;
                        state_r <= S_NULL;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ring3_sink.sv
// Randomized scoreboard bench for ring3_sink: tokens are predicted from the ring
// rules, a monitor pops expectations whenever the DUT hands a token over.
module tb_ring3_sink;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          init = 1'b1;
    logic [2:0]    C = 3'b000;
    logic          TCOMP;
    logic [1:0]    dout;
    logic          dout_valid;
    logic          dout_ready = 1'b0;
    logic          code_err;
    logic          seq_err;
    logic [CW-1:0] tok_count;

    int   checks = 0;
    int   failures = 0;
    bit   rand_ready = 1'b0;
    logic [1:0] exp_q[$];

    int m_cnt;
    int m_ref;
    bit m_have_ref;
    bit m_seq;
    bit m_code;

    ring3_sink #(.SYNC_STAGES(2), .STABLE_CYCLES(2), .CNT_W(CW), .SEQ_STEP(1)) dut (
        .clk(clk), .init(init), .C(C), .TCOMP(TCOMP), .dout(dout),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .code_err(code_err),
        .seq_err(seq_err), .tok_count(tok_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) dout_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic model_token(input int v);
        exp_q.push_back(2'(v));
        m_cnt++;
        if (m_have_ref && (v != (m_ref + 1) % 3)) m_seq = 1'b1;
        m_ref      = v;
        m_have_ref = 1'b1;
    endtask

    task automatic model_clear();
        m_cnt = 0; m_ref = 0; m_have_ref = 1'b0; m_seq = 1'b0; m_code = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_flags(input string tag);
        chk({tag, "_tok_count"}, 32'(tok_count), 32'(m_cnt % (1 << CW)));
        chk({tag, "_seq_err"}, 32'(seq_err), 32'(m_seq));
        chk({tag, "_code_err"}, 32'(code_err), 32'(m_code));
    endtask

    task automatic wait_tcomp(input logic val, input int limit, output int n);
        n = 0;
        while (TCOMP !== val && n < limit) begin
            tick();
            n++;
        end
        chk("tcomp_wait", 32'(TCOMP), 32'(val));
    endtask

    task automatic do_reset();
        init = 1'b1;
        C    = 3'b000;
        repeat (3) tick();
        init = 1'b0;
        model_clear();
    endtask

    task automatic send_token(input int v);
        int n;
        C = 3'b001 << v;
        model_token(v);
        wait_tcomp(1'b1, 60, n);
        check_flags("token");
        repeat (2) tick();
        C = 3'b000;
        wait_tcomp(1'b0, 60, n);
        tick();
    endtask

    // Monitor: each valid&ready handshake consumes the oldest expected token.
    initial begin
        forever begin
            @(negedge clk);
            if (dout_valid && dout_ready && !init) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_token actual=%0d required=none", dout);
                end else begin
                    chk("dout", 32'(dout), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        int n;
        model_clear();

        // Reset held with DATA on the rails, then first-token latency.
        C = 3'b010;
        dout_ready = 1'b1;
        repeat (3) begin
            tick();
            chk("reset_outputs", {TCOMP, dout_valid, dout, code_err, seq_err, 24'(tok_count)}, 32'd0);
        end
        init = 1'b0;
        model_token(1);
        wait_tcomp(1'b1, 20, n);
        chk("first_latency", 32'(n), 32'd4);
        chk("first_dout", 32'(dout), 32'd1);
        check_flags("first");
        C = 3'b000;
        wait_tcomp(1'b0, 20, n);
        tick();

        // Clean ring rotation.
        do_reset();
        foreach (exp_q[i]) chk("queue_flush", 32'(exp_q.size()), 32'd0);
        send_token(0); send_token(1); send_token(2); send_token(0);
        chk("ring_count", 32'(tok_count), 32'd4);

        // Backpressure: second token waits in hold until the consumer is ready.
        do_reset();
        dout_ready = 1'b0;
        send_token(0);
        C = 3'b010;
        repeat (8) tick();
        chk("hold_tcomp", 32'(TCOMP), 32'd0);
        chk("hold_dout", 32'(dout), 32'd0);
        chk("hold_valid", 32'(dout_valid), 32'd1);
        model_token(1);
        dout_ready = 1'b1;
        tick();
        chk("release_tcomp", 32'(TCOMP), 32'd1);
        chk("release_dout", 32'(dout), 32'd1);
        chk("release_count", 32'(tok_count), 32'd2);
        C = 3'b000;
        wait_tcomp(1'b0, 20, n);
        tick();

        // Rotation order violation and resynchronization.
        do_reset();
        send_token(0);
        send_token(2);
        chk("seq_set", 32'(seq_err), 32'd1);
        send_token(0);
        chk("seq_sticky", 32'(seq_err), 32'd1);
        do_reset();
        chk("seq_cleared", 32'(seq_err), 32'd0);

        // Different DATA while in the data phase.
        C = 3'b001;
        model_token(0);
        wait_tcomp(1'b1, 20, n);
        C = 3'b010;
        repeat (6) tick();
        m_code = 1'b1;
        chk("data_swap_tcomp", 32'(TCOMP), 32'd1);
        check_flags("data_swap");
        C = 3'b000;
        wait_tcomp(1'b0, 20, n);
        tick();

        // Illegal code, then a one-cycle glitch inside NULL.
        do_reset();
        C = 3'b011;
        repeat (5) tick();
        m_code = 1'b1;
        chk("illegal_tcomp", 32'(TCOMP), 32'd0);
        check_flags("illegal");
        C = 3'b000;
        repeat (6) tick();
        C = 3'b100;
        tick();
        C = 3'b000;
        repeat (8) tick();
        chk("glitch_tcomp", 32'(TCOMP), 32'd0);
        chk("glitch_count", 32'(tok_count), 32'd0);

        // Random tokens and random backpressure across a counter wrap.
        do_reset();
        rand_ready = 1'b1;
        for (int i = 0; i < 16; i++) send_token(int'($urandom_range(0, 2)));
        chk("wrap_count", 32'(tok_count), 32'd0);
        rand_ready = 1'b0;
        dout_ready = 1'b1;
        repeat (3) tick();
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        // Reset while a token is held in the data phase.
        do_reset();
        dout_ready = 1'b0;
        C = 3'b001;
        model_token(0);
        wait_tcomp(1'b1, 20, n);
        chk("pre_reset_valid", 32'(dout_valid), 32'd1);
        init = 1'b1;
        tick();
        chk("midreset_tcomp", 32'(TCOMP), 32'd0);
        chk("midreset_valid", 32'(dout_valid), 32'd0);
        chk("midreset_count", 32'(tok_count), 32'd0);
        C = 3'b000;
        init = 1'b0;
        model_clear();
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
